// File: rtl/stoch_signed_decode.sv
// Signed stochastic bitstream decoder: integrates (x_p - x_m) over 2^WINDOW_BITS
// cycles and returns the two's-complement count behind a valid/ready handshake.
module stoch_signed_decode #(
    parameter int unsigned WINDOW_BITS = 8,
    localparam int unsigned OUT_WIDTH = WINDOW_BITS + 2
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 start,
    input  logic                 x_p,
    input  logic                 x_m,
    output logic                 busy,
    output logic [OUT_WIDTH-1:0] y,
    output logic                 y_valid,
    input  logic                 y_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   acc_q, acc_d;
    logic [WINDOW_BITS-1:0] cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   y_d;
    logic                   y_valid_d;
    logic                   busy_d;
    logic [OUT_WIDTH-1:0]   inc;

    // Per-sample step; equal channels cancel.
    always_comb begin
        inc = '0;
        case ({x_p, x_m})
            2'b10:   inc = OUT_WIDTH'(1);
            2'b01:   inc = '1;
            default: inc = '0;
        endcase
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        y_d       = y;
        y_valid_d = y_valid;
        busy_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                acc_d = acc_q + inc;
                cnt_d = cnt_q + WINDOW_BITS'(1);
                // Window closes on the wrap edge; that edge's sample is included.
                if (&cnt_q) begin
                    state_d   = DONE;
                    y_d       = acc_d;
                    y_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (y_ready) begin
                    state_d   = IDLE;
                    y_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == ACCUM);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            y       <= y_d;
            y_valid <= y_valid_d;
            busy    <= busy_d;
        end
    end

endmodule
